systolic_fir_array: RTL

SYSTOLIC_FIR_ARRAY -- requirements
Module: systolic_fir_array

---
 rtl/systolic_fir_array.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/systolic_fir_array.sv
// systolic_fir_array: TAPS-stage systolic FIR with a cascade partial-sum input.
// Each accepted sample launches a partial sum that walks one PE per cycle and
// picks up w[k]*x(n-k) at PE k. A result register adds the final cycle, so
// y_valid follows the accept by TAPS+1 cycles regardless of input gaps.
// Optional feature macro: SYSTOLIC_FIR_SAT_EN (saturate the final sum to ACC_W
// bits instead of wrapping).
module systolic_fir_array #(
  parameter  int WIDTH = 8,
  parameter  int TAPS  = 4,
  localparam int ACC_W = 2*WIDTH + $clog2(TAPS) + 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic signed [WIDTH-1:0] x_data,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic signed [ACC_W-1:0] yin,
  input  logic                    w_load,
  input  logic signed [WIDTH-1:0] w_data,
  input  logic                    w_valid,
  output logic signed [ACC_W-1:0] y,
  output logic                    y_valid,
  output logic                    busy
);

`ifdef SYSTOLIC_FIR_SAT_EN
  // One guard bit so the clamp can see overflow of the final sum.
  localparam int SUM_W = ACC_W + 1;
`else
  localparam int SUM_W = ACC_W;
`endif
  localparam int CNT_W = $clog2(TAPS);

  typedef enum logic [1:0] {StRun, StDrain, StLoad} state_e;

  state_e                  state_q;
  logic                    x_ready_q;
  logic                    busy_q;
  logic [CNT_W-1:0]        cnt_q;
  logic signed [WIDTH-1:0] w_q    [TAPS];
  logic signed [WIDTH-1:0] hist_q [TAPS-1];
  // Sample window travelling with each partial sum: win_q[k][j] = x(n-j).
  logic signed [WIDTH-1:0] win_q  [TAPS-1][TAPS];
  logic signed [SUM_W-1:0] psum_q [TAPS];
  logic [TAPS-1:0]         vld_q;
  logic signed [ACC_W-1:0] y_q;
  logic signed [ACC_W-1:0] y_d;
  logic                    y_valid_q;
  logic signed [2*WIDTH-1:0] prod [TAPS];
  logic                    accept;
  logic                    last_beat;

  assign accept    = x_valid && x_ready_q;
  assign last_beat = (state_q == StLoad) && w_valid && (cnt_q == CNT_W'(TAPS - 1));

  // Full-precision products, one per PE.
  always_comb begin
    prod[0] = (2*WIDTH)'(w_q[0]) * (2*WIDTH)'(x_data);
    for (int k = 1; k < TAPS; k++) begin
      prod[k] = (2*WIDTH)'(w_q[k]) * (2*WIDTH)'(win_q[k-1][k]);
    end
  end

  // Control FSM with registered x_ready/busy.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StRun;
      x_ready_q <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (w_load) begin
            state_q   <= StDrain;
            x_ready_q <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        StDrain: begin
          // Empty PE chain means the last in-flight result is in y_q this cycle.
          if (vld_q == '0) state_q <= StLoad;
        end
        StLoad: begin
          if (last_beat) begin
            state_q   <= StRun;
            x_ready_q <= 1'b1;
            busy_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= StRun;
          x_ready_q <= 1'b1;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  // Weight loading and sample history; history only moves on accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int i = 0; i < TAPS; i++) w_q[i] <= '0;
      for (int j = 0; j < TAPS - 1; j++) hist_q[j] <= '0;
    end else if ((state_q == StLoad) && w_valid) begin
      for (int i = 0; i < TAPS; i++) begin
        if (cnt_q == CNT_W'(i)) w_q[i] <= w_data;
      end
      if (last_beat) begin
        cnt_q <= '0;
        for (int j = 0; j < TAPS - 1; j++) hist_q[j] <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else if (accept) begin
      hist_q[0] <= x_data;
      for (int j = 1; j < TAPS - 1; j++) hist_q[j] <= hist_q[j-1];
    end
  end

  // PE chain; data advances every cycle, only vld_q marks live entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < TAPS; k++) psum_q[k] <= '0;
      for (int k = 0; k < TAPS - 1; k++) begin
        for (int j = 0; j < TAPS; j++) win_q[k][j] <= '0;
      end
    end else begin
      vld_q       <= {vld_q[TAPS-2:0], accept};
      psum_q[0]   <= SUM_W'(yin) + SUM_W'(prod[0]);
      win_q[0][0] <= x_data;
      for (int j = 1; j < TAPS; j++) win_q[0][j] <= hist_q[j-1];
      for (int k = 1; k < TAPS; k++) psum_q[k] <= psum_q[k-1] + SUM_W'(prod[k]);
      for (int k = 1; k < TAPS - 1; k++) win_q[k] <= win_q[k-1];
    end
  end

  // Final sum: clamp on guard-bit disagreement, or plain two's-complement wrap.
  always_comb begin
`ifdef SYSTOLIC_FIR_SAT_EN
    if (psum_q[TAPS-1][SUM_W-1] != psum_q[TAPS-1][SUM_W-2]) begin
      y_d = psum_q[TAPS-1][SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end else begin
      y_d = psum_q[TAPS-1][ACC_W-1:0];
    end
`else
    y_d = psum_q[TAPS-1];
`endif
  end

  // Result register; y holds its last value between pulses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      y_valid_q <= vld_q[TAPS-1];
      if (vld_q[TAPS-1]) y_q <= y_d;
    end
  end

  assign x_ready = x_ready_q;
  assign busy    = busy_q;
  assign y       = y_q;
  assign y_valid = y_valid_q;

endmodule
